// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM states,
// opcode/funct encodings and ALU operation codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's 2-bit ALU request plus the R-type funct field onto the
// 3-bit ALU operation code.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unrecognised funct codes fall back to add.
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle MIPS datapath, with a
// retired-instruction counter and an illegal-opcode pulse.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             iord,
    output logic             irwrite,
    output logic             memwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             alusrca,
    output logic             pcwrite,
    output logic             regwrite,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             retired,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    state_t     state, next_state;
    logic [1:0] aluop;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        pcwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        retired    = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                irwrite    = 1'b1;
                alusrcb    = 2'b01;
                pcwrite    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively computes the branch target while decoding.
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default: begin
                        illegal    = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == OP_LW)      next_state = S_MEMRD;
                else if (op == OP_SW) next_state = S_MEMWR;
                else                  next_state = S_FETCH;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                retired  = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                retired  = 1'b1;
            end
            S_EXEC: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                retired  = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                pcwrite = zero;
                retired = 1'b1;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                retired  = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                retired = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    // Free-running wrap on overflow is intended.
    always_ff @(posedge clk) begin
        if (reset)        retired_cnt <= '0;
        else if (retired) retired_cnt <= retired_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each instruction pushes its
// hand-written per-cycle control words; a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic       iord, irwrite, memwrite, regdst, memtoreg, alusrca, pcwrite, regwrite;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alucontrol;
        logic       retired, illegal;
    } ctrl_t;

    typedef struct {
        ctrl_t            ctrl;
        logic [CNT_W-1:0] cnt;
        string            name;
    } exp_t;

    // Fields: iord irw mw rd mtr asa pcw rw | srcb | pcsrc | alu | ret ill
    localparam ctrl_t W_FETCH   = 17'b0_1_0_0_0_0_1_0_01_00_010_0_0;
    localparam ctrl_t W_DECODE  = 17'b0_0_0_0_0_0_0_0_11_00_010_0_0;
    localparam ctrl_t W_DEC_ILL = 17'b0_0_0_0_0_0_0_0_11_00_010_0_1;
    localparam ctrl_t W_MEMADR  = 17'b0_0_0_0_0_1_0_0_10_00_010_0_0;
    localparam ctrl_t W_MEMRD   = 17'b1_0_0_0_0_0_0_0_00_00_010_0_0;
    localparam ctrl_t W_MEMWB   = 17'b0_0_0_0_1_0_0_1_00_00_010_1_0;
    localparam ctrl_t W_MEMWR   = 17'b1_0_1_0_0_0_0_0_00_00_010_1_0;
    localparam ctrl_t W_EXEC    = 17'b0_0_0_0_0_1_0_0_00_00_000_0_0;
    localparam ctrl_t W_ALUWB   = 17'b0_0_0_1_0_0_0_1_00_00_010_1_0;
    localparam ctrl_t W_BR_NT   = 17'b0_0_0_0_0_1_0_0_00_01_110_1_0;
    localparam ctrl_t W_BR_T    = 17'b0_0_0_0_0_1_1_0_00_01_110_1_0;
    localparam ctrl_t W_ADDIEX  = 17'b0_0_0_0_0_1_0_0_10_00_010_0_0;
    localparam ctrl_t W_ADDIWB  = 17'b0_0_0_0_0_0_0_1_00_00_010_1_0;
    localparam ctrl_t W_JUMP    = 17'b0_0_0_0_0_0_1_0_00_10_010_1_0;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       op, funct;
    logic             zero;
    logic             iord, irwrite, memwrite, regdst, memtoreg, alusrca, pcwrite, regwrite;
    logic [1:0]       alusrcb, pcsrc;
    logic [2:0]       alucontrol;
    logic             retired, illegal;
    logic [CNT_W-1:0] retired_cnt;

    exp_t             exp_q[$];
    logic [CNT_W-1:0] model_cnt;
    int               checks = 0;
    int               errors = 0;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .iord        (iord),
        .irwrite     (irwrite),
        .memwrite    (memwrite),
        .regdst      (regdst),
        .memtoreg    (memtoreg),
        .alusrca     (alusrca),
        .pcwrite     (pcwrite),
        .regwrite    (regwrite),
        .alusrcb     (alusrcb),
        .pcsrc       (pcsrc),
        .alucontrol  (alucontrol),
        .retired     (retired),
        .illegal     (illegal),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic pushWord(input ctrl_t w, input string name);
        exp_t e;
        e.ctrl = w;
        e.cnt  = model_cnt;
        e.name = name;
        exp_q.push_back(e);
        if (w.retired) model_cnt = model_cnt + 1'b1;
    endtask

    task automatic checkOutput(input exp_t e);
        ctrl_t act;
        act = {iord, irwrite, memwrite, regdst, memtoreg, alusrca, pcwrite, regwrite,
               alusrcb, pcsrc, alucontrol, retired, illegal};
        checks++;
        if (act !== e.ctrl) begin
            errors++;
            $display("[TB] FAIL %s ctrl: actual=%b required=%b", e.name, act, e.ctrl);
        end
        checks++;
        if (retired_cnt !== e.cnt) begin
            errors++;
            $display("[TB] FAIL %s retired_cnt: actual=%0d required=%0d", e.name, retired_cnt, e.cnt);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    // Entered and left at posedge+1 of a FETCH cycle; exec_alu is the
    // hand-decoded ALU code expected during EXEC for R-type instructions.
    task automatic applyStimulus(input logic [5:0] op_i, input logic [5:0] funct_i,
                                 input logic zero_i, input logic [2:0] exec_alu,
                                 input string name);
        ctrl_t w_exec;
        int    n;
        op     = op_i;
        funct  = funct_i;
        zero   = zero_i;
        w_exec = W_EXEC;
        w_exec.alucontrol = exec_alu;
        pushWord(W_FETCH, {name, ".fetch"});
        case (op_i)
            6'b100011: begin
                pushWord(W_DECODE, {name, ".decode"});
                pushWord(W_MEMADR, {name, ".memadr"});
                pushWord(W_MEMRD,  {name, ".memrd"});
                pushWord(W_MEMWB,  {name, ".memwb"});
                n = 5;
            end
            6'b101011: begin
                pushWord(W_DECODE, {name, ".decode"});
                pushWord(W_MEMADR, {name, ".memadr"});
                pushWord(W_MEMWR,  {name, ".memwr"});
                n = 4;
            end
            6'b000000: begin
                pushWord(W_DECODE, {name, ".decode"});
                pushWord(w_exec,   {name, ".exec"});
                pushWord(W_ALUWB,  {name, ".aluwb"});
                n = 4;
            end
            6'b000100: begin
                pushWord(W_DECODE, {name, ".decode"});
                pushWord(zero_i ? W_BR_T : W_BR_NT, {name, ".branch"});
                n = 3;
            end
            6'b001000: begin
                pushWord(W_DECODE, {name, ".decode"});
                pushWord(W_ADDIEX, {name, ".addiex"});
                pushWord(W_ADDIWB, {name, ".addiwb"});
                n = 4;
            end
            6'b000010: begin
                pushWord(W_DECODE, {name, ".decode"});
                pushWord(W_JUMP,   {name, ".jump"});
                n = 3;
            end
            default: begin
                pushWord(W_DEC_ILL, {name, ".decode"});
                n = 2;
            end
        endcase
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyResetDuringMemrd();
        op    = 6'b100011;
        funct = 6'b000000;
        zero  = 1'b0;
        pushWord(W_FETCH,  "lw_rst.fetch");
        pushWord(W_DECODE, "lw_rst.decode");
        pushWord(W_MEMADR, "lw_rst.memadr");
        pushWord(W_MEMRD,  "lw_rst.memrd");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        model_cnt = '0;
    endtask

    initial begin
        reset     = 1'b1;
        op        = 6'b000000;
        funct     = 6'b000000;
        zero      = 1'b0;
        model_cnt = '0;
        @(posedge clk);
        #1;
        pushWord(W_FETCH, "reset.fetch");
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(6'b100011, 6'b000000, 1'b0, 3'b000, "lw");
        applyStimulus(6'b101011, 6'b000000, 1'b0, 3'b000, "sw");
        applyStimulus(6'b000000, 6'b101010, 1'b0, 3'b111, "slt");
        applyStimulus(6'b000000, 6'b100000, 1'b0, 3'b010, "add");
        applyStimulus(6'b000000, 6'b100010, 1'b0, 3'b110, "sub");
        applyStimulus(6'b000000, 6'b100100, 1'b0, 3'b000, "and");
        applyStimulus(6'b000000, 6'b100101, 1'b0, 3'b001, "or");
        applyStimulus(6'b000000, 6'b111111, 1'b0, 3'b010, "rtype_unknown");
        applyStimulus(6'b000100, 6'b000000, 1'b0, 3'b000, "beq_nt");
        applyStimulus(6'b000100, 6'b000000, 1'b1, 3'b000, "beq_t");
        applyStimulus(6'b001000, 6'b000000, 1'b0, 3'b000, "addi");
        applyStimulus(6'b111111, 6'b000000, 1'b0, 3'b000, "illegal_3f");
        applyStimulus(6'b000001, 6'b000000, 1'b0, 3'b000, "illegal_01");
        applyResetDuringMemrd();
        for (int i = 0; i < 16; i++) applyStimulus(6'b000010, 6'b000000, 1'b0, 3'b000, "j_wrap");
        applyStimulus(6'b100011, 6'b000000, 1'b0, 3'b000, "lw_after_wrap");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
